// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - main control FSM for the multi-cycle RV32I core (optional MCYC_ILLEGAL_TRAP_EN)
module mcycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       InstrRetired
`ifdef MCYC_ILLEGAL_TRAP_EN
  ,
  output logic       IllegalInstr
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LINKWB   = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_AUIPC    = 4'd14;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [3:0] state_q, state_d;
  logic       taken;
  logic       known_op;

  assign taken = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
  assign known_op = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) || (op == OP_I) ||
                    (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR) ||
                    (op == OP_LUI) || (op == OP_AUIPC);

  // State register; reset returns to the configured entry state from anywhere.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`ifdef MCYC_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_LINKWB;
      S_AUIPC:    state_d = S_ALUWB;
`ifdef MCYC_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state; forced to 0 in reset.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
    if (rst) ImmSrc = 3'b000;
  end

  // Moore outputs per state, with the memory/branch gating; reset zeroes everything.
  always_comb begin
    MemReq = 1'b0; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUOp = 2'b00; ResultSrc = 2'b00;
    AdrSrc = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    InstrRetired = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemReq = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        IRWrite = MemReady; PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
`ifndef MCYC_ILLEGAL_TRAP_EN
        InstrRetired = !known_op;
`endif
      end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  begin MemReq = 1'b1; AdrSrc = 1'b1; end
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; InstrRetired = 1'b1; end
      S_MEMWRITE: begin
        MemReq = 1'b1; AdrSrc = 1'b1; MemWrite = MemReady; InstrRetired = MemReady;
      end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
      S_ALUWB:    begin RegWrite = 1'b1; InstrRetired = 1'b1; end
      S_BRANCH:   begin ALUSrcA = 2'b10; ALUOp = 2'b01; InstrRetired = 1'b1; PCWrite = taken; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1; end
      S_LINKWB: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; RegWrite = 1'b1; InstrRetired = 1'b1;
      end
      S_LUI:      begin ResultSrc = 2'b11; RegWrite = 1'b1; InstrRetired = 1'b1; end
      S_AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      default: ;
    endcase
    if (rst) begin
      MemReq = 1'b0; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUOp = 2'b00; ResultSrc = 2'b00;
      AdrSrc = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
      InstrRetired = 1'b0;
    end
  end

`ifdef MCYC_ILLEGAL_TRAP_EN
  assign IllegalInstr = (state_q == S_TRAP) && !rst;
`else
  logic unused_known_op;
  assign unused_known_op = known_op;
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb/tb_mcycle_ctrl.sv - randomized model-checked bench for mcycle_ctrl
module tb_mcycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, InstrRetired;
  logic [2:0] ImmSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
`ifdef MCYC_ILLEGAL_TRAP_EN
  logic       IllegalInstr;
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;
  bit new_instr = 1'b0;

  always #5 clk = ~clk;

  mcycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .InstrRetired(InstrRetired)
`ifdef MCYC_ILLEGAL_TRAP_EN
    , .IllegalInstr(IllegalInstr)
`endif
  );

  // Instruction classes of the reference model
  localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5,
                 C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_NOP = 9;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_NOP;
    endcase
  endfunction

  // Number of the final cycle of an instruction, counting fetch as cycle 0
  function automatic int last_k(input int c);
    case (c)
      C_LOAD:        return 4;
      C_BR, C_LUI:   return 2;
      C_NOP:         return 1;
      default:       return 3;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input int c);
    case (c)
      C_STORE:         return 3'd1;
      C_BR:            return 3'd2;
      C_JAL:           return 3'd3;
      C_LUI, C_AUIPC:  return 3'd4;
      default:         return 3'd0;
    endcase
  endfunction

  // Expected output vector: {MemReq,ImmSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc,AdrSrc,IRWrite,PCWrite,RegWrite,MemWrite,InstrRetired}
  function automatic logic [17:0] exp_vec(input int c, input int k, input bit trap, input bit r,
                                          input logic [2:0] f3, input bit z, input bit mr);
    logic mq, ad, iw, pw, rw, mw, rt;
    logic [1:0] a, b, ao, rs;
    mq = 0; ad = 0; iw = 0; pw = 0; rw = 0; mw = 0; rt = 0; a = 0; b = 0; ao = 0; rs = 0;
    if (r) return 18'd0;
    if (!trap) begin
      if (k == 0) begin
        mq = 1; b = 2; rs = 2; iw = mr; pw = mr;
      end else if (k == 1) begin
        a = 1; b = 1; rt = (c == C_NOP) && !TRAP_EN;
      end else begin
        case (c)
          C_LOAD, C_STORE: begin
            if (k == 2) begin a = 2; b = 1; end
            else if (k == 3) begin
              mq = 1; ad = 1;
              if (c == C_STORE) begin mw = mr; rt = mr; end
            end else begin rs = 1; rw = 1; rt = 1; end
          end
          C_R, C_I: begin
            if (k == 2) begin a = 2; b = (c == C_I) ? 2'd1 : 2'd0; ao = 2; end
            else begin rw = 1; rt = 1; end
          end
          C_BR: begin
            a = 2; ao = 1; rt = 1;
            pw = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z);
          end
          C_JAL: begin
            if (k == 2) begin a = 1; b = 2; pw = 1; end
            else begin rw = 1; rt = 1; end
          end
          C_JALR: begin
            if (k == 2) begin a = 2; b = 1; rs = 2; pw = 1; end
            else begin a = 1; b = 2; rs = 2; rw = 1; rt = 1; end
          end
          C_LUI: begin rs = 3; rw = 1; rt = 1; end
          C_AUIPC: begin
            if (k == 2) begin a = 1; b = 1; end
            else begin rw = 1; rt = 1; end
          end
          default: ;
        endcase
      end
    end
    return {mq, imm_of(c), a, b, ao, rs, ad, iw, pw, rw, mw, rt};
  endfunction

  // Reference model state: cycle index within the instruction and trap flag
  int m_k = 0;
  bit m_trap = 1'b0;

  // Compare process: check every cycle at the falling edge, then advance the model
  always @(negedge clk) begin
    int c;
    bit waiting;
    logic [17:0] dv;
    c = cls_of(op);
    dv = {MemReq, ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, AdrSrc, IRWrite, PCWrite,
          RegWrite, MemWrite, InstrRetired};
    chk("outputs", {14'd0, dv}, {14'd0, exp_vec(c, m_k, m_trap, rst, funct3, Zero, MemReady)});
`ifdef MCYC_ILLEGAL_TRAP_EN
    chk("IllegalInstr", {31'd0, IllegalInstr}, {31'd0, m_trap && !rst});
`endif
    if (rst) begin
      m_k = 0; m_trap = 1'b0;
    end else if (!m_trap) begin
      waiting = (m_k == 0 || (m_k == 3 && (c == C_LOAD || c == C_STORE))) && !MemReady;
      if (!waiting) begin
        if (m_k == 0) new_instr = 1'b1;
        if (m_k == last_k(c)) begin
          m_k = 0;
          if (c == C_NOP && TRAP_EN) m_trap = 1'b1;
        end else m_k++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] op_tab [11];

  initial begin
    op_tab = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00, 7'h7F};
    rst = 1; op = 7'b0110011; funct3 = 3'd0; Zero = 0; MemReady = 1;
    cyc(); cyc();
    #1 chk("reset MemReq", {31'd0, MemReq}, 32'd0);
    chk("reset ALUSrcB", {30'd0, ALUSrcB}, 32'd0);
    // R-type with memory always ready
    rst = 0;
    #1 chk("R c1 IRWrite", {31'd0, IRWrite}, 32'd1);
    chk("R c1 RegWrite", {31'd0, RegWrite}, 32'd0);
    cyc(); #1 chk("R c2 ALUSrcA", {30'd0, ALUSrcA}, 32'd1);
    chk("R c2 InstrRetired", {31'd0, InstrRetired}, 32'd0);
    cyc(); #1 chk("R c3 ALUOp", {30'd0, ALUOp}, 32'd2);
    cyc(); #1 chk("R c4 RegWrite", {31'd0, RegWrite}, 32'd1);
    chk("R c4 InstrRetired", {31'd0, InstrRetired}, 32'd1);
    // lui: three cycles
    cyc(); op = 7'b0110111;
    #1 chk("lui fetch MemReq", {31'd0, MemReq}, 32'd1);
    chk("lui ImmSrc", {29'd0, ImmSrc}, 32'd4);
    cyc(); cyc(); #1 chk("lui ResultSrc", {30'd0, ResultSrc}, 32'd3);
    chk("lui RegWrite", {31'd0, RegWrite}, 32'd1);
    // store interrupted by reset while waiting for memory
    cyc(); op = 7'b0100011;
    cyc(); MemReady = 0;
    cyc(); cyc();
    #1 chk("memwrite MemReq", {31'd0, MemReq}, 32'd1);
    chk("memwrite MemWrite", {31'd0, MemWrite}, 32'd0);
    chk("store AdrSrc", {31'd0, AdrSrc}, 32'd1);
    rst = 1;
    #1 chk("rst MemReq", {31'd0, MemReq}, 32'd0);
    cyc(); rst = 0;
    #1 chk("after rst MemReq", {31'd0, MemReq}, 32'd1);
    chk("after rst AdrSrc", {31'd0, AdrSrc}, 32'd0);
    chk("after rst MemWrite", {31'd0, MemWrite}, 32'd0);
    // Random instruction stream
    new_instr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (new_instr) begin
        op = op_tab[$urandom_range(0, 10)];
        funct3 = 3'($urandom_range(0, 7));
        new_instr = 1'b0;
      end
      rst = ($urandom_range(0, 39) == 0);
      MemReady = ($urandom_range(0, 2) != 0);
      Zero = 1'($urandom_range(0, 1));
    end
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
